// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, the zero-register
// index, and the bundle of six stage-register controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_MEM_WAIT,
    ST_ERROR
  } state_t;

  localparam logic [31:0] REG_ZERO = 32'd0;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_bubble;
    logic ex_mem_we;
  } ctrl_vec_t;

  // Field order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we
  localparam ctrl_vec_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_vec_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_vec_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch flush,
// return flush and data-memory freeze, with a sticky memory-timeout error.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_USES_RT,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_MEM_READ,
  input  logic             EX_BRANCH_TAKEN,
  input  logic             ID_ret_enable,
  input  logic             DM_BUSY,
  output logic             PC_WE,
  output logic             IF_ID_WE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_WE,
  output logic             ID_EX_BUBBLE,
  output logic             EX_MEM_WE,
  output logic             HAZ_ERROR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int FL_W = $clog2(FLUSH_DEPTH + 1);
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FL_W-1:0] FLUSH_RELOAD = FL_W'(FLUSH_DEPTH - 1);
  localparam logic [FL_W-1:0] FLUSH_ONE    = FL_W'(1);
  localparam logic [WT_W-1:0] WAIT_LIMIT   = WT_W'(MEM_TIMEOUT);
  localparam logic [WT_W-1:0] WAIT_ONE     = WT_W'(1);

  state_t           r_state, r_saved_state;
  logic [FL_W-1:0]  r_flush_left;
  logic [WT_W-1:0]  r_wait_cnt;

  state_t           w_next_state, w_next_saved, w_eff_state;
  logic [FL_W-1:0]  w_next_flush;
  logic [WT_W-1:0]  w_next_wait;
  logic             w_load_use;
  ctrl_vec_t        w_ctrl;

  assign w_load_use = EX_MEM_READ && (EX_RD != REG_ZERO[REG_W-1:0]) &&
                      ((EX_RD == ID_RS) || (ID_USES_RT && (EX_RD == ID_RT)));

  // Leaving MEM_WAIT behaves exactly like the saved state would in that cycle.
  assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_saved_state : r_state;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ctrl       = CTRL_FREEZE;
    w_next_state = r_state;
    w_next_saved = r_saved_state;
    w_next_flush = r_flush_left;
    w_next_wait  = r_wait_cnt;

    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else if (r_state == ST_ERROR) begin
      w_ctrl = CTRL_FREEZE;
    end else if (DM_BUSY) begin
      w_ctrl = CTRL_FREEZE;
      if (r_state == ST_MEM_WAIT) begin
        w_next_wait = r_wait_cnt + WAIT_ONE;
      end else begin
        w_next_saved = r_state;
        w_next_wait  = WAIT_ONE;
      end
      w_next_state = (w_next_wait >= WAIT_LIMIT) ? ST_ERROR : ST_MEM_WAIT;
    end else begin
      w_ctrl       = CTRL_RUN;
      w_next_state = w_eff_state;
      if (w_eff_state == ST_FLUSH) begin
        w_ctrl.if_id_flush = 1'b1;
        w_next_flush       = r_flush_left - FLUSH_ONE;
        if (r_flush_left == FLUSH_ONE) w_next_state = ST_RUN;
      end
      if (EX_BRANCH_TAKEN) begin
        w_ctrl.if_id_flush  = 1'b1;
        w_ctrl.id_ex_bubble = 1'b1;
        w_next_flush        = FLUSH_RELOAD;
        w_next_state        = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
      end else if (w_load_use) begin
        w_ctrl.pc_we        = 1'b0;
        w_ctrl.if_id_we     = 1'b0;
        w_ctrl.id_ex_bubble = 1'b1;
      end else if (ID_ret_enable) begin
        w_ctrl.if_id_flush = 1'b1;
      end
    end
  end

  // NOTE: only control flops are reset here; there is no memory array to clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_saved_state <= ST_RUN;
      r_flush_left  <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_saved_state <= w_next_saved;
      r_flush_left  <= w_next_flush;
      r_wait_cnt    <= w_next_wait;
    end
  end

  assign PC_WE        = w_ctrl.pc_we;
  assign IF_ID_WE     = w_ctrl.if_id_we;
  assign IF_ID_FLUSH  = w_ctrl.if_id_flush;
  assign ID_EX_WE     = w_ctrl.id_ex_we;
  assign ID_EX_BUBBLE = w_ctrl.id_ex_bubble;
  assign EX_MEM_WE    = w_ctrl.ex_mem_we;
  assign HAZ_ERROR    = (r_state == ST_ERROR);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~w_ctrl.pc_we),
    .count (STALL_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ctrl.if_id_flush),
    .count (FLUSH_CNT)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// expected per-cycle outputs come from a cycle-count model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int REG_W       = 5;
  localparam int FLUSH_DEPTH = 2;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic             id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch = 1'b0;
  logic             id_ret = 1'b0, dm_busy = 1'b0;

  logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we;
  logic             haz_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .FLUSH_DEPTH(FLUSH_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_RS           (id_rs),
    .ID_RT           (id_rt),
    .ID_USES_RT      (id_uses_rt),
    .EX_RD           (ex_rd),
    .EX_MEM_READ     (ex_mem_read),
    .EX_BRANCH_TAKEN (ex_branch),
    .ID_ret_enable   (id_ret),
    .DM_BUSY         (dm_busy),
    .PC_WE           (pc_we),
    .IF_ID_WE        (if_id_we),
    .IF_ID_FLUSH     (if_id_flush),
    .ID_EX_WE        (id_ex_we),
    .ID_EX_BUBBLE    (id_ex_bubble),
    .EX_MEM_WE       (ex_mem_we),
    .HAZ_ERROR       (haz_error),
    .STALL_CNT       (stall_cnt),
    .FLUSH_CNT       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected response for one cycle; ctrl = {pc, if_id_we, flush, id_ex_we, bubble, ex_mem_we, haz}
  typedef struct {
    logic [6:0] ctrl;
    int         stall;
    int         flushc;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle    = 0;

  // Reference model state: plain counts, no state encoding.
  bit   m_err;
  int   m_flush_left, m_wait, m_stall, m_flushc;
  exp_t m_last;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic bit load_use();
    return ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    bit pc, ifwe, fl, idwe, bub, exwe;
    e.cyc = cycle;
    if (!rst_n) begin
      e.ctrl = 7'b0010100;
      e.stall = 0;
      e.flushc = 0;
      return e;
    end
    {pc, ifwe, fl, idwe, bub, exwe} = 6'b000000;
    if (!m_err && !dm_busy) begin
      {pc, ifwe, idwe, exwe} = 4'b1111;
      fl = (m_flush_left > 0);
      if (ex_branch) begin
        fl = 1; bub = 1;
      end else if (load_use()) begin
        pc = 0; ifwe = 0; bub = 1;
      end else if (id_ret) begin
        fl = 1;
      end
    end
    e.ctrl   = {pc, ifwe, fl, idwe, bub, exwe, m_err};
    e.stall  = m_stall;
    e.flushc = m_flushc;
    return e;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle just ended.
  task automatic model_edge();
    if (!rst_n) begin
      m_err = 0; m_flush_left = 0; m_wait = 0; m_stall = 0; m_flushc = 0;
      return;
    end
    if (!m_last.ctrl[6] && m_stall < CNT_MAX) m_stall++;
    if (m_last.ctrl[4] && m_flushc < CNT_MAX) m_flushc++;
    if (m_err) return;
    if (dm_busy) begin
      m_wait++;
      if (m_wait >= MEM_TIMEOUT) m_err = 1;
    end else begin
      m_wait = 0;
      if (ex_branch) m_flush_left = FLUSH_DEPTH - 1;
      else if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic drive(input bit rst, input int rs, input int rt, input bit urt,
                       input int rd, input bit mr, input bit br, input bit ret,
                       input bit busy);
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    rst_n       = rst;
    id_rs       = REG_W'(rs);
    id_rt       = REG_W'(rt);
    id_uses_rt  = urt;
    ex_rd       = REG_W'(rd);
    ex_mem_read = mr;
    ex_branch   = br;
    id_ret      = ret;
    dm_busy     = busy;
    m_last = model_outputs();
    exp_q.push_back(m_last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 2, 1, 5, 0, 0, 0, 0);
  endtask

  task automatic busy_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 2, 1, 5, 0, 0, 0, 1);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ctrl", e.cyc,
              {25'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, haz_error},
              {25'd0, e.ctrl});
        check("stall_cnt", e.cyc, 32'(stall_cnt), 32'(e.stall));
        check("flush_cnt", e.cyc, 32'(flush_cnt), 32'(e.flushc));
      end
    end
  end

  initial begin
    int burst;
    m_err = 0; m_flush_left = 0; m_wait = 0; m_stall = 0; m_flushc = 0;
    m_last.ctrl = 7'b0010100;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on RS, then zero register, RT unused, RT used
    drive(1, 3, 7, 1, 3, 1, 0, 0, 0);
    idle(1);
    drive(1, 0, 7, 1, 0, 1, 0, 0, 0);
    drive(1, 4, 6, 0, 6, 1, 0, 0, 0);
    drive(1, 4, 6, 1, 6, 1, 0, 0, 0);
    idle(1);
    // Branch flush, then branch with memory wait mid-flush
    drive(1, 1, 2, 1, 5, 0, 1, 0, 0);
    idle(3);
    drive(1, 1, 2, 1, 5, 0, 1, 0, 0);
    busy_cycles(4);
    idle(3);
    // Return, and return masked by load-use
    drive(1, 1, 2, 1, 5, 0, 0, 1, 0);
    drive(1, 9, 2, 1, 9, 1, 0, 1, 0);
    idle(1);
    // Freeze beats branch and load-use
    drive(1, 3, 3, 1, 3, 1, 1, 1, 1);
    idle(3);
    // Timeout, sticky error, reset clears
    busy_cycles(MEM_TIMEOUT);
    idle(4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Async reset mid-wait
    busy_cycles(5);
    drive(0, 1, 2, 1, 5, 0, 0, 0, 1);
    idle(2);
    // Park in ERROR long enough for the stall counter to saturate
    busy_cycles(MEM_TIMEOUT);
    idle(CNT_MAX + 10);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    burst = 0;
    for (int c = 0; c < 2500; c++) begin
      bit busy;
      if (burst > 0) begin
        busy = 1;
        burst--;
      end else begin
        busy = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(1, 18);
      end
      drive(($urandom_range(0, 199) != 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15), busy);
    end

    @(negedge clk);
    #1;
    check("drain", cycle, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
